// File: rtl/score_pkg.sv
// Shared glyph geometry, colour key and converter FSM encoding for the score overlay.
package score_pkg;
    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 10;
    localparam int GLYPH_SIZE = GLYPH_W * GLYPH_H;
    localparam int MAX_SCORE = 9999;
    localparam logic [11:0] TRANSPARENT = 12'h0F0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit per SHIFT cycle, with the BCD
// result published in a single COMMIT cycle so readers never see a partial value.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [BIN_W-1:0]    i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [DIGITS*4-1:0] o_bcd
);
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [BIN_W-1:0]    r_bin;
    logic [DIGITS*4-1:0] r_work;
    logic [DIGITS*4-1:0] w_adj;
    logic [DIGITS*4-1:0] r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_load;

    // A start in COMMIT chains straight into the next conversion.
    assign w_load = i_start && (r_state != SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nx = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_state_nx = COMMIT;
            COMMIT:  w_state_nx = i_start ? SHIFT : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_work[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_work[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_bin  <= i_bin;
            r_work <= '0;
            r_cnt  <= '0;
        end else if (r_state == SHIFT) begin
            r_bin  <= r_bin << 1;
            r_work <= {w_adj[DIGITS*4-2:0], r_bin[BIN_W-1]};
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd <= '0;
        end else if (r_state == COMMIT) begin
            r_bcd <= r_work;
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == COMMIT);
    assign o_bcd  = r_bcd;
endmodule

// File: rtl/score_display_ctrl.sv
// Score overlay: converts the binary score to decimal digits and streams
// colour-keyed glyph pixels to the VGA mixer with a fixed 3-cycle latency.
module score_display_ctrl #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 9,
    parameter int SCORE_WIDTH = 14,
    parameter int NUM_DIGITS  = 4,
    parameter int GLYPH_W     = score_pkg::GLYPH_W,
    parameter int GLYPH_H     = score_pkg::GLYPH_H,
    parameter int SCALE_LOG2  = 1,
    parameter int POS_X       = 16,
    parameter int POS_Y       = 16,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = score_pkg::TRANSPARENT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SCORE_WIDTH-1:0] score_i,
    input  logic                   score_we,
    output logic                   busy,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    output logic                   score_on,
    output logic [DATA_WIDTH-1:0]  score_rgb
);
    import score_pkg::*;

    localparam int SPAN  = GLYPH_W << SCALE_LOG2;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [9:0] X_LO = 10'(POS_X);
    localparam logic [9:0] X_HI = 10'(POS_X + NUM_DIGITS * SPAN);
    localparam logic [9:0] Y_LO = 10'(POS_Y);
    localparam logic [9:0] Y_HI = 10'(POS_Y + (GLYPH_H << SCALE_LOG2));
    localparam logic [ADDR_WIDTH-1:0] A_GSIZE = ADDR_WIDTH'(GLYPH_W * GLYPH_H);
    localparam logic [ADDR_WIDTH-1:0] A_GW    = ADDR_WIDTH'(GLYPH_W);

    function automatic logic [SCORE_WIDTH-1:0] clamp_score(input logic [SCORE_WIDTH-1:0] s);
        return (s > SCORE_WIDTH'(MAX_SCORE)) ? SCORE_WIDTH'(MAX_SCORE) : s;
    endfunction

    logic [SCORE_WIDTH-1:0]  w_score_clamped;
    logic [SCORE_WIDTH-1:0]  w_start_val;
    logic [SCORE_WIDTH-1:0]  r_pend_val;
    logic                    r_pend_vld;
    logic                    w_start;
    logic                    w_bb_busy;
    logic                    w_bb_done;
    logic [NUM_DIGITS*4-1:0] w_bcd;

    logic [9:0]              w_dx, w_dy, w_base, w_col, w_row;
    logic [IDX_W-1:0]        w_idx;
    logic [3:0]              w_digit;
    logic                    w_region;
    logic                    w_key;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH-1:0]   r_rom_addr;
    logic                    r_region_p1, r_region_p2, r_on_p3;
    logic [DATA_WIDTH-1:0]   r_rgb_p3;

    assign w_score_clamped = clamp_score(score_i);

    // Writes during COMMIT win over an older pending value and restart at once.
    always_comb begin
        w_start     = 1'b0;
        w_start_val = w_score_clamped;
        if (!w_bb_busy) begin
            w_start = score_we;
        end else if (w_bb_done) begin
            w_start = score_we || r_pend_vld;
            if (!score_we) w_start_val = r_pend_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_vld <= 1'b0;
        end else if (w_bb_done) begin
            r_pend_vld <= 1'b0;
        end else if (score_we && w_bb_busy) begin
            r_pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (score_we && w_bb_busy && !w_bb_done) r_pend_val <= w_score_clamped;
    end

    bin2bcd_seq #(
        .BIN_W  (SCORE_WIDTH),
        .DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (w_start_val),
        .o_busy  (w_bb_busy),
        .o_done  (w_bb_done),
        .o_bcd   (w_bcd)
    );

    assign busy = w_bb_busy;

    assign w_region = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                      (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    assign w_dx = pixel_x - X_LO;
    assign w_dy = pixel_y - Y_LO;

    always_comb begin
        w_idx   = '0;
        w_base  = '0;
        w_digit = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (w_dx >= 10'(i * SPAN)) begin
                w_idx  = IDX_W'(i);
                w_base = 10'(i * SPAN);
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == IDX_W'(i)) w_digit = w_bcd[(NUM_DIGITS-1-i)*4 +: 4];
        end
    end

    assign w_col  = (w_dx - w_base) >> SCALE_LOG2;
    assign w_row  = w_dy >> SCALE_LOG2;
    assign w_addr = ADDR_WIDTH'(w_digit) * A_GSIZE + ADDR_WIDTH'(w_row) * A_GW + ADDR_WIDTH'(w_col);
    assign w_key  = r_region_p2 && (rom_data != TRANSPARENT);

    // p1 issues the ROM address, p2 waits on the ROM read, p3 applies the colour key.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rom_addr  <= '0;
            r_region_p1 <= 1'b0;
            r_region_p2 <= 1'b0;
            r_on_p3     <= 1'b0;
            r_rgb_p3    <= '0;
        end else begin
            r_rom_addr  <= w_region ? w_addr : '0;
            r_region_p1 <= w_region;
            r_region_p2 <= r_region_p1;
            r_on_p3     <= w_key;
            r_rgb_p3    <= w_key ? rom_data : '0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign score_on  = r_on_p3;
    assign score_rgb = r_rgb_p3;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized bench for score_display_ctrl against a behavioural display model
// built from integer digit arithmetic and a cycle-count conversion timeline.
module tb_score_display_ctrl;
    localparam logic [11:0] TRANSP = 12'h0F0;
    localparam int CONV_CYCLES = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        score_we = 1'b0;
    logic [13:0] score_i = '0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        busy;
    logic [8:0]  rom_addr;
    logic [11:0] rom_data;
    logic        score_on;
    logic [11:0] score_rgb;

    logic [11:0] rom_mem [0:499];
    logic [11:0] rom_q = '0;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    int busy_left = 0;
    int cur = 0;
    int pend_val = 0;
    int disp = 0;
    int p1_addr = 0;
    bit pend_v = 0;
    bit p1_reg = 0;
    bit p2_reg = 0;
    bit m_on = 0;
    bit chk_en = 0;
    logic [11:0] p2_data = '0;
    logic [11:0] m_rgb = '0;

    score_display_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .score_i   (score_i),
        .score_we  (score_we),
        .busy      (busy),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .score_on  (score_on),
        .score_rgb (score_rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= (rom_addr < 9'd500) ? rom_mem[rom_addr] : 12'h000;
    assign rom_data = rom_q;

    function automatic int clampv(int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic bit in_region(int x, int y);
        return (x >= 16) && (x < 56) && (y >= 16) && (y < 36);
    endfunction

    function automatic int glyph_addr(int x, int y, int val);
        int dx = x - 16;
        int idx = dx / 10;
        int p = 1;
        for (int k = idx; k < 3; k++) p = p * 10;
        return ((val / p) % 10) * 50 + ((y - 16) / 2) * 5 + (dx % 10) / 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_px(input int x, input int y);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk("wait_idle", {31'd0, busy}, 0);
    endtask

    task automatic sweep();
        for (int y = 12; y < 40; y++) begin
            for (int x = 10; x < 60; x++) begin
                set_px(x, y);
                tick();
            end
        end
    endtask

    task automatic strobe(input int v);
        score_i = 14'(v);
        score_we = 1'b1;
        tick();
        score_we = 1'b0;
    endtask

    // Reference model: display value changes only at the end of a conversion.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            busy_left = 0; pend_v = 0; disp = 0;
            p1_reg = 0; p1_addr = 0; p2_reg = 0; p2_data = '0;
            m_on = 0; m_rgb = '0;
            chk_en = 1;
        end else begin
            m_on = p2_reg && (p2_data != TRANSP);
            m_rgb = m_on ? p2_data : 12'h000;
            p2_reg = p1_reg;
            p2_data = rom_mem[p1_addr];
            p1_reg = in_region(int'(pixel_x), int'(pixel_y));
            p1_addr = p1_reg ? glyph_addr(int'(pixel_x), int'(pixel_y), disp) : 0;
            if (busy_left == 0) begin
                if (score_we) begin cur = clampv(int'(score_i)); busy_left = CONV_CYCLES; end
            end else if (busy_left == 1) begin
                disp = cur;
                if (score_we) begin cur = clampv(int'(score_i)); busy_left = CONV_CYCLES; end
                else if (pend_v) begin cur = pend_val; busy_left = CONV_CYCLES; end
                else busy_left = 0;
                pend_v = 0;
            end else begin
                busy_left--;
                if (score_we) begin pend_v = 1; pend_val = clampv(int'(score_i)); end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, (busy_left > 0) ? 1 : 0);
            chk("rom_addr", {23'd0, rom_addr}, p1_addr);
            chk("score_on", {31'd0, score_on}, {31'd0, m_on});
            chk("score_rgb", {20'd0, score_rgb}, {20'd0, m_rgb});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 500; i++) begin
            rom_mem[i] = ($urandom_range(2, 0) == 0) ? TRANSP : 12'($urandom_range(4095, 0));
        end

        chk("model_addr_1234", glyph_addr(26, 16, 1234), 100);
        chk("model_addr_9999", glyph_addr(55, 35, 9999), 499);
        chk("model_addr_0_r1c1", glyph_addr(18, 18, 0), 6);
        chk("model_region_left", {31'd0, in_region(15, 16)}, 0);
        chk("model_region_right", {31'd0, in_region(56, 16)}, 0);
        chk("model_clamp", clampv(12000), 9999);

        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_rom_addr", {23'd0, rom_addr}, 0);
        chk("reset_score_on", {31'd0, score_on}, 0);
        chk("reset_score_rgb", {20'd0, score_rgb}, 0);

        set_px(16, 16); tick();
        chk("zero_addr_16_16", {23'd0, rom_addr}, 0);
        set_px(18, 18); tick();
        chk("zero_addr_18_18", {23'd0, rom_addr}, 6);
        sweep();

        strobe(1234);
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; tick(); end
        chk("busy_len_1234", n, 15);
        set_px(26, 16); tick();
        chk("addr_1234_26_16", {23'd0, rom_addr}, 100);
        sweep();

        strobe(12000);
        wait_idle(40);
        set_px(55, 35); tick();
        chk("addr_clamp_55_35", {23'd0, rom_addr}, 499);

        set_px(46, 16);
        strobe(42);
        tick(); tick();
        strobe(77);
        tick(); tick();
        strobe(88);
        repeat (10) tick();
        chk("pend_first_42", {23'd0, rom_addr}, 100);
        chk("pend_restart_busy", {31'd0, busy}, 1);
        wait_idle(40);
        tick();
        chk("pend_last_88", {23'd0, rom_addr}, 400);

        rom_mem[400] = TRANSP;
        rom_mem[401] = 12'hABC;
        set_px(46, 16); repeat (3) tick();
        chk("transp_on", {31'd0, score_on}, 0);
        chk("transp_rgb", {20'd0, score_rgb}, 0);
        set_px(48, 16); repeat (3) tick();
        chk("opaque_on", {31'd0, score_on}, 1);
        chk("opaque_rgb", {20'd0, score_rgb}, 32'hABC);

        set_px(15, 16); tick();
        chk("left_edge_addr", {23'd0, rom_addr}, 0);
        tick(); tick();
        chk("left_edge_on", {31'd0, score_on}, 0);
        set_px(56, 16); tick();
        chk("right_edge_addr", {23'd0, rom_addr}, 0);
        tick(); tick();
        chk("right_edge_on", {31'd0, score_on}, 0);

        set_px(48, 18);
        strobe(5678);
        tick();
        strobe(4321);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        repeat (40) tick();
        chk("abort_no_commit_busy", {31'd0, busy}, 0);
        chk("abort_digits_zero", {23'd0, rom_addr}, 6);

        for (int i = 0; i < 4000; i++) begin
            set_px(int'($urandom_range(64, 8)), int'($urandom_range(42, 10)));
            score_we = ($urandom_range(11, 0) == 0);
            score_i = 14'($urandom_range(16383, 0));
            reset = ($urandom_range(599, 0) == 0);
            tick();
        end
        score_we = 1'b0;
        reset = 1'b0;
        wait_idle(60);
        sweep();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
